// File: rtl/boid_frame_plotter_pkg.sv
// Shared screen geometry, FSM encodings and the square-raster step helper used by the
// boid plotter and its neighbours (wrapper, VGA controller).
package boid_frame_plotter_pkg;

  localparam int VIDEO_WIDTH         = 640;
  localparam int VIDEO_HEIGHT        = 480;
  localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT);
  localparam int MAX_BOIDS           = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SWAP  = 3'd1;
  localparam logic [2:0] ST_ERASE = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_DRAW  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
    logic       last;
  } raster_t;

  // Next (dx,dy) inside a square of side size_m1+1, dx fastest; last flags the final pixel.
  function automatic raster_t raster_next(input logic [1:0] dx,
                                          input logic [1:0] dy,
                                          input logic [1:0] size_m1);
    raster_t r;
    r.dx   = dx + 2'd1;
    r.dy   = dy;
    r.last = 1'b0;
    if (dx == size_m1) begin
      r.dx = 2'd0;
      if (dy == size_m1) begin
        r.dy   = 2'd0;
        r.last = 1'b1;
      end else begin
        r.dy = dy + 2'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/boid_frame_plotter_if.sv
// Plotter-side bus: coordinate fetch from the BPU array and the pixel write port.
// master = plotter, slave = BPU array / pixel RAM side.
interface boid_frame_plotter_if #(
  parameter int SEL_W      = 3,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 9,
  parameter int ADDR_WIDTH = 19
);
  logic [SEL_W-1:0]      boid_sel;
  logic [X_WIDTH-1:0]    boid_x;
  logic [Y_WIDTH-1:0]    boid_y;
  logic                  fb_we;
  logic                  fb_buf;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic                  fb_data;

  modport master (
    output boid_sel, fb_we, fb_buf, fb_addr, fb_data,
    input  boid_x, boid_y
  );

  modport slave (
    input  boid_sel, fb_we, fb_buf, fb_addr, fb_data,
    output boid_x, boid_y
  );
endinterface

// File: rtl/boid_frame_plotter_pos_store.sv
// Per-buffer record of where each boid was last drawn: 2 x NUM_BOIDS {valid,x,y},
// one synchronous write port, asynchronous read, valid bits cleared by reset.
module boid_frame_plotter_pos_store #(
  parameter int NUM_BOIDS = 8,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 9,
  parameter int SEL_W     = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic               wr_buf,
  input  logic [SEL_W-1:0]   wr_idx,
  input  logic [X_WIDTH-1:0] wr_x,
  input  logic [Y_WIDTH-1:0] wr_y,
  input  logic               rd_buf,
  input  logic [SEL_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [X_WIDTH-1:0] rd_x,
  output logic [Y_WIDTH-1:0] rd_y
);
  localparam int DEPTH = 2 * NUM_BOIDS;

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [X_WIDTH-1:0] x_q [DEPTH];
  logic [X_WIDTH-1:0] x_d [DEPTH];
  logic [Y_WIDTH-1:0] y_q [DEPTH];
  logic [Y_WIDTH-1:0] y_d [DEPTH];
  logic [SEL_W:0]     wr_addr, rd_addr;

  // Buffer b occupies entries b*NUM_BOIDS .. b*NUM_BOIDS+NUM_BOIDS-1.
  assign wr_addr = (SEL_W+1)'(wr_buf ? NUM_BOIDS : 0) + (SEL_W+1)'(wr_idx);
  assign rd_addr = (SEL_W+1)'(rd_buf ? NUM_BOIDS : 0) + (SEL_W+1)'(rd_idx);

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (wr_en) begin
      valid_d[wr_addr] = 1'b1;
      x_d[wr_addr]     = wr_x;
      y_d[wr_addr]     = wr_y;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  assign rd_valid = valid_q[rd_addr];
  assign rd_x     = x_q[rd_addr];
  assign rd_y     = y_q[rd_addr];

endmodule

// File: rtl/boid_frame_plotter.sv
// Double-buffered boid plotter: on frame_start swap buffers, erase old squares in the new back
// buffer, then fetch and draw every boid. 1+sum(erase)+N*(1+S^2)+1 cycles; no backpressure.
module boid_frame_plotter #(
  parameter int NUM_BOIDS    = 8,
  parameter int X_WIDTH      = 10,
  parameter int Y_WIDTH      = 9,
  parameter int VIDEO_WIDTH  = boid_frame_plotter_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boid_frame_plotter_pkg::VIDEO_HEIGHT,
  parameter int BOID_SIZE    = 2,
  parameter int ADDR_WIDTH   = boid_frame_plotter_pkg::PIXEL_ADDRESS_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_start,
  boid_frame_plotter_if.master bus,
  output logic                 display_buf,
  output logic                 busy,
  output logic                 overrun
);
  import boid_frame_plotter_pkg::*;

  localparam int               SEL_W    = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BOIDS - 1);
  localparam logic [1:0]       SIZE_M1  = 2'(BOID_SIZE - 1);
  localparam logic [X_WIDTH:0] X_LIMIT  = (X_WIDTH+1)'(VIDEO_WIDTH);
  localparam logic [Y_WIDTH:0] Y_LIMIT  = (Y_WIDTH+1)'(VIDEO_HEIGHT);

  logic [2:0]            state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [1:0]            dx_q, dx_d;
  logic [1:0]            dy_q, dy_d;
  logic                  disp_q, disp_d;
  logic                  fb_we_q, fb_we_d;
  logic                  fb_buf_q, fb_buf_d;
  logic                  fb_data_q, fb_data_d;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                  overrun_q, overrun_d;

  logic                  back_buf;
  logic                  first_draw;
  logic                  st_valid;
  logic [X_WIDTH-1:0]    st_x, cur_x;
  logic [Y_WIDTH-1:0]    st_y, cur_y;
  logic [X_WIDTH:0]      px;
  logic [Y_WIDTH:0]      py;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] pix_addr;
  raster_t               step;

  assign back_buf   = ~disp_q;
  assign first_draw = (state_q == ST_DRAW) && (dx_q == 2'd0) && (dy_q == 2'd0);

  boid_frame_plotter_pos_store #(
    .NUM_BOIDS (NUM_BOIDS),
    .X_WIDTH   (X_WIDTH),
    .Y_WIDTH   (Y_WIDTH),
    .SEL_W     (SEL_W)
  ) u_pos_store (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (first_draw),
    .wr_buf   (back_buf),
    .wr_idx   (idx_q),
    .wr_x     (bus.boid_x),
    .wr_y     (bus.boid_y),
    .rd_buf   (back_buf),
    .rd_idx   (idx_q),
    .rd_valid (st_valid),
    .rd_x     (st_x),
    .rd_y     (st_y)
  );

  // The BPU coordinates are only guaranteed on the first DRAW cycle; later cycles use the copy just stored.
  assign cur_x    = first_draw ? bus.boid_x : st_x;
  assign cur_y    = first_draw ? bus.boid_y : st_y;
  assign px       = {1'b0, cur_x} + (X_WIDTH+1)'(dx_q);
  assign py       = {1'b0, cur_y} + (Y_WIDTH+1)'(dy_q);
  assign in_range = (px < X_LIMIT) && (py < Y_LIMIT);
  assign pix_addr = ADDR_WIDTH'(py) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(px);
  assign step     = raster_next(dx_q, dy_q, SIZE_M1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    disp_d    = disp_q;
    fb_we_d   = 1'b0;
    fb_data_d = fb_data_q;
    fb_addr_d = fb_addr_q;
    overrun_d = frame_start && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        disp_d  = ~disp_q;
        idx_d   = '0;
        sel_d   = '0;
        dx_d    = 2'd0;
        dy_d    = 2'd0;
        state_d = ST_ERASE;
      end
      ST_ERASE: begin
        if (st_valid) begin
          fb_we_d   = in_range;
          fb_data_d = 1'b0;
          if (in_range) begin
            fb_addr_d = pix_addr;
          end
          dx_d = step.dx;
          dy_d = step.dy;
        end
        // Empty slots cost one cycle; drawn slots move on after their last pixel.
        if (!st_valid || step.last) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_FETCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        fb_we_d   = in_range;
        fb_data_d = 1'b1;
        if (in_range) begin
          fb_addr_d = pix_addr;
        end
        dx_d = step.dx;
        dy_d = step.dy;
        if (step.last) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            sel_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fb_buf_d = ~disp_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sel_q     <= '0;
      dx_q      <= 2'd0;
      dy_q      <= 2'd0;
      disp_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_buf_q  <= 1'b1;
      fb_data_q <= 1'b0;
      fb_addr_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      disp_q    <= disp_d;
      fb_we_q   <= fb_we_d;
      fb_buf_q  <= fb_buf_d;
      fb_data_q <= fb_data_d;
      fb_addr_q <= fb_addr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.boid_sel = sel_q;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_buf   = fb_buf_q;
  assign bus.fb_addr  = fb_addr_q;
  assign bus.fb_data  = fb_data_q;
  assign display_buf  = disp_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;

endmodule
